// File: rtl/tmds_period_scheduler.sv
// TMDS period scheduler: delays video/control through an L-stage pipeline and,
// when a line start is qualified in HDMI mode, overwrites the blank words that
// precede it with a video preamble and a video guard band.
module tmds_period_scheduler #(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2
) (
  input  logic       pixel_clk,
  input  logic       rst,
  input  logic       hdmi_mode,
  input  logic       de_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] vid_ch0,
  input  logic [9:0] vid_ch1,
  input  logic [9:0] vid_ch2,
  input  logic       err_clr,
  output logic [9:0] out_ch0,
  output logic [9:0] out_ch1,
  output logic [9:0] out_ch2,
  output logic       short_blank_err
);

  // Insertion window: the preamble and guard band replace exactly L blank
  // words, so the pipeline must be that deep to reach back far enough.
  localparam int L         = PREAMBLE_LEN + GUARD_LEN;
  localparam int MIN_BLANK = L + 2;

  localparam logic [3:0] MIN_BLANK_C = 4'(MIN_BLANK);
  localparam logic [3:0] PRE_LAST    = 4'(PREAMBLE_LEN - 1);
  localparam logic [3:0] GUARD_LAST  = 4'(GUARD_LEN - 1);
  localparam logic [3:0] BLANK_SAT   = 4'd15;

  // Control tokens indexed by {c1,c0}, written bit9..bit0
  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  // Video guard-band words (ch0/ch2 share a pattern, ch1 is its complement)
  localparam logic [9:0] GB_CH0 = 10'b1011001100;
  localparam logic [9:0] GB_CH1 = 10'b0100110011;
  localparam logic [9:0] GB_CH2 = 10'b1011001100;

  function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
    logic [9:0] tok;
    tok = TOK_00;
    unique case ({c1, c0})
      2'b00: tok = TOK_00;
      2'b01: tok = TOK_01;
      2'b10: tok = TOK_10;
      2'b11: tok = TOK_11;
    endcase
    return tok;
  endfunction

  // One pipeline stage carries everything needed to rebuild an output word
  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [9:0] v0;
    logic [9:0] v1;
    logic [9:0] v2;
  } stage_t;

  typedef enum logic [1:0] {
    S_CTRL  = 2'd0,
    S_PRE   = 2'd1,
    S_GUARD = 2'd2,
    S_VIDEO = 2'd3
  } state_t;

  stage_t     pipe_q [L];
  stage_t     in_word;
  stage_t     tail;

  logic [3:0] blank_cnt_q;
  logic [3:0] blank_cnt_d;
  logic       de_prev_q;
  logic       de_rise;
  logic       blank_ok;
  logic       qual_edge;
  logic       short_set;
  logic       err_q;
  logic       err_d;

  state_t     state_q;
  logic [3:0] phase_q;

  logic [9:0] plain_ch0;
  logic [9:0] plain_ch1;
  logic [9:0] plain_ch2;
  logic [9:0] pre_ch0;
  logic [9:0] out_ch0_q;
  logic [9:0] out_ch1_q;
  logic [9:0] out_ch2_q;

  // Pack the inputs into a pipeline word and expose the oldest stage
  always_comb begin
    in_word    = '0;
    in_word.de = de_in;
    in_word.hs = hsync_in;
    in_word.vs = vsync_in;
    in_word.v0 = vid_ch0;
    in_word.v1 = vid_ch1;
    in_word.v2 = vid_ch2;
    tail       = pipe_q[L-1];
  end

  // L-deep delay line; reset flushes it to blank with both syncs low
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      for (int i = 0; i < L; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= in_word;
      for (int i = 1; i < L; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Line-start detection and blanking-length qualification on the live input
  always_comb begin
    de_rise     = de_in & ~de_prev_q;
    blank_ok    = (blank_cnt_q >= MIN_BLANK_C);
    qual_edge   = de_rise & hdmi_mode & blank_ok;
    short_set   = de_rise & hdmi_mode & ~blank_ok;
    blank_cnt_d = blank_cnt_q;
    if (de_in) begin
      blank_cnt_d = 4'd0;
    end else if (blank_cnt_q != BLANK_SAT) begin
      blank_cnt_d = blank_cnt_q + 4'd1;
    end
    // A set in the same cycle as a clear wins so no short line goes unseen
    err_d = short_set | (err_q & ~err_clr);
  end

  // Blank counter, previous DE and the sticky short-blank flag
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      blank_cnt_q <= 4'd0;
      de_prev_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      blank_cnt_q <= blank_cnt_d;
      de_prev_q   <= de_in;
      err_q       <= err_d;
    end
  end

  // Candidate output words built from the oldest pipeline stage
  always_comb begin
    pre_ch0   = ctrl_token(tail.vs, tail.hs);
    plain_ch0 = tail.de ? tail.v0 : pre_ch0;
    plain_ch1 = tail.de ? tail.v1 : TOK_00;
    plain_ch2 = tail.de ? tail.v2 : TOK_00;
  end

  // Insertion FSM with registered channel words. A qualified edge at the
  // input means the oldest stage holds the first word of the insertion
  // window, so the first preamble word is emitted on the same clock that
  // the FSM leaves CTRL.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q   <= S_CTRL;
      phase_q   <= 4'd0;
      out_ch0_q <= TOK_00;
      out_ch1_q <= TOK_00;
      out_ch2_q <= TOK_00;
    end else begin
      unique case (state_q)
        S_CTRL: begin
          if (qual_edge) begin
            out_ch0_q <= pre_ch0;
            out_ch1_q <= TOK_01;
            out_ch2_q <= TOK_00;
            if (PREAMBLE_LEN == 1) begin
              state_q <= S_GUARD;
              phase_q <= 4'd0;
            end else begin
              state_q <= S_PRE;
              phase_q <= 4'd1;
            end
          end else begin
            out_ch0_q <= plain_ch0;
            out_ch1_q <= plain_ch1;
            out_ch2_q <= plain_ch2;
          end
        end
        S_PRE: begin
          out_ch0_q <= pre_ch0;
          out_ch1_q <= TOK_01;
          out_ch2_q <= TOK_00;
          if (phase_q == PRE_LAST) begin
            state_q <= S_GUARD;
            phase_q <= 4'd0;
          end else begin
            phase_q <= phase_q + 4'd1;
          end
        end
        S_GUARD: begin
          out_ch0_q <= GB_CH0;
          out_ch1_q <= GB_CH1;
          out_ch2_q <= GB_CH2;
          if (phase_q == GUARD_LAST) begin
            state_q <= S_VIDEO;
            phase_q <= 4'd0;
          end else begin
            phase_q <= phase_q + 4'd1;
          end
        end
        S_VIDEO: begin
          out_ch0_q <= plain_ch0;
          out_ch1_q <= plain_ch1;
          out_ch2_q <= plain_ch2;
          if (!tail.de) begin
            state_q <= S_CTRL;
          end
        end
      endcase
    end
  end

  assign out_ch0         = out_ch0_q;
  assign out_ch1         = out_ch1_q;
  assign out_ch2         = out_ch2_q;
  assign short_blank_err = err_q;

endmodule

// File: tb/tb_tmds_period_scheduler.sv
// Directed bench for tmds_period_scheduler with a scoreboard queue of
// expected output words. Preamble/guard rewrites are applied to queued
// entries when the model sees a qualified line start.
module tb_tmds_period_scheduler;

  localparam int P         = 8;
  localparam int G         = 2;
  localparam int L         = P + G;
  localparam int MIN_BLANK = L + 2;

  typedef struct packed {
    logic [1:0] sync;   // {vs,hs} of the cycle
    logic [9:0] c0;
    logic [9:0] c1;
    logic [9:0] c2;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       hdmi_mode = 1'b0;
  logic       de_in = 1'b0;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic [9:0] vid_ch0 = '0;
  logic [9:0] vid_ch1 = '0;
  logic [9:0] vid_ch2 = '0;
  logic       err_clr = 1'b0;
  logic [9:0] out_ch0;
  logic [9:0] out_ch1;
  logic [9:0] out_ch2;
  logic       short_blank_err;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  exp_t q[$];
  int   m_blank;
  logic m_de_prev;
  logic m_err;

  tmds_period_scheduler #(
    .PREAMBLE_LEN (P),
    .GUARD_LEN    (G)
  ) dut (
    .pixel_clk       (clk),
    .rst             (rst),
    .hdmi_mode       (hdmi_mode),
    .de_in           (de_in),
    .hsync_in        (hsync_in),
    .vsync_in        (vsync_in),
    .vid_ch0         (vid_ch0),
    .vid_ch1         (vid_ch1),
    .vid_ch2         (vid_ch2),
    .err_clr         (err_clr),
    .out_ch0         (out_ch0),
    .out_ch1         (out_ch1),
    .out_ch2         (out_ch2),
    .short_blank_err (short_blank_err)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] tok(input logic [1:0] vs_hs);
    logic [9:0] t;
    case (vs_hs)
      2'b00:   t = 10'b1101010100;
      2'b01:   t = 10'b0010101011;
      2'b10:   t = 10'b0101010100;
      default: t = 10'b1010101011;
    endcase
    return t;
  endfunction

  task automatic check10(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  // Hold reset for n cycles, then restart the model with a flushed pipeline
  task automatic do_reset(input int n);
    exp_t z;
    repeat (n) begin
      @(posedge clk); #1;
      rst = 1'b1; de_in = 1'b0; err_clr = 1'b0;
      cyc++;
    end
    q.delete();
    z.sync = 2'b00; z.c0 = 10'b1101010100; z.c1 = 10'b1101010100; z.c2 = 10'b1101010100;
    for (int i = 0; i < L + 1; i++) q.push_back(z);
    m_blank = 0; m_de_prev = 1'b0; m_err = 1'b0;
  endtask

  // One pixel clock: drive, predict, then compare the word leaving the DUT
  task automatic step(input logic de, input logic hs, input logic vs,
                      input logic mode, input logic clr);
    exp_t e, o;
    logic rise, qual;
    int   idx;
    @(posedge clk); #1;
    rst = 1'b0; de_in = de; hsync_in = hs; vsync_in = vs;
    hdmi_mode = mode; err_clr = clr;
    vid_ch0 = 10'($urandom); vid_ch1 = 10'($urandom); vid_ch2 = 10'($urandom);
    rise = de && !m_de_prev;
    qual = rise && mode && (m_blank >= MIN_BLANK);
    e.sync = {vs, hs};
    e.c0 = de ? vid_ch0 : tok({vs, hs});
    e.c1 = de ? vid_ch1 : 10'b1101010100;
    e.c2 = de ? vid_ch2 : 10'b1101010100;
    q.push_back(e);
    if (qual) begin
      for (int k = 1; k <= L; k++) begin
        idx = q.size() - 1 - k;
        if (k > G) begin
          q[idx].c0 = tok(q[idx].sync);
          q[idx].c1 = 10'b0010101011;
          q[idx].c2 = 10'b1101010100;
        end else begin
          q[idx].c0 = 10'b1011001100;
          q[idx].c1 = 10'b0100110011;
          q[idx].c2 = 10'b1011001100;
        end
      end
    end
    @(negedge clk);
    if (q.size() == L + 2) begin
      o = q.pop_front();
      check10("ch0", out_ch0, o.c0);
      check10("ch1", out_ch1, o.c1);
      check10("ch2", out_ch2, o.c2);
      $display("cycle %0d de=%b mode=%b out=%h/%h/%h exp=%h/%h/%h err=%b",
               cyc, de, mode, out_ch0, out_ch1, out_ch2, o.c0, o.c1, o.c2, short_blank_err);
    end
    check1("err", short_blank_err, m_err);
    m_err     = (rise && mode && !qual) | (m_err & ~clr);
    m_blank   = de ? 0 : m_blank + 1;
    m_de_prev = de;
    cyc++;
  endtask

  task automatic blank(input int n, input logic mode);
    repeat (n) step(1'b0, 1'b0, 1'b0, mode, 1'b0);
  endtask

  task automatic line(input int n, input logic mode);
    repeat (n) step(1'b1, 1'b0, 1'b0, mode, 1'b0);
  endtask

  task automatic blank_sync(input int n, input logic hs, input logic vs);
    repeat (n) step(1'b0, hs, vs, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and basic HDMI insertion after a long blank
    do_reset(3);
    blank(20, 1'b1);
    line(16, 1'b1);
    blank(14, 1'b1);

    // DVI mode: plain control words, no insertion
    do_reset(2);
    blank(20, 1'b0);
    line(8, 1'b0);
    blank(14, 1'b0);

    // Short gap in HDMI mode: no insertion, sticky error, clear
    line(8, 1'b1);
    blank(11, 1'b1);
    line(8, 1'b1);
    blank(13, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    blank(3, 1'b1);

    // Set and clear in the same cycle: flag stays set
    line(4, 1'b1);
    blank(3, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    line(3, 1'b1);
    blank(14, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    blank(2, 1'b1);

    // Short gap in DVI mode never flags
    line(4, 1'b0);
    blank(3, 1'b0);
    line(4, 1'b0);
    blank(14, 1'b0);

    // Sync levels during preamble: vsync high, then random sync per cycle
    blank_sync(14, 1'b0, 1'b1);
    line(6, 1'b1);
    for (int i = 0; i < 14; i++) step(1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
    line(6, 1'b1);
    blank(14, 1'b1);

    // Reset in the middle of the guard band, then a normal insertion
    line(9, 1'b1);
    do_reset(1);
    blank(12, 1'b1);
    line(12, 1'b1);
    blank(14, 1'b1);

    // Edge after only 11 blanks from reset release is not qualified
    do_reset(1);
    blank(11, 1'b1);
    line(4, 1'b1);
    blank(14, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Mode dropped during preamble: insertion completes, next line is DVI
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    line(7, 1'b0);
    blank(14, 1'b0);
    line(6, 1'b0);
    blank(14, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_period_scheduler.md
TMDS_PERIOD_SCHEDULER -- requirements
Module: tmds_period_scheduler

Interface
REQ-001 SHALL have parameter PREAMBLE_LEN, default 8: preamble length in pixel clocks, legal 1..8.
REQ-002 SHALL have parameter GUARD_LEN, default 2: video guard-band length in pixel clocks, legal 1..2.
REQ-003 SHALL define L = PREAMBLE_LEN+GUARD_LEN and MIN_BLANK = L+2 (defaults 10 and 12).
REQ-004 pixel_clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 hdmi_mode  input  1  1 = insert preamble/guard band; 0 = plain DVI control periods.
REQ-007 de_in  input  1  data enable, active video.
REQ-008 hsync_in, vsync_in  input  1 each  sync levels, passed as ch0 control bits.
REQ-009 vid_ch0, vid_ch1, vid_ch2  input  10 each  pre-encoded TMDS video words; bit0 transmitted first.
REQ-010 err_clr  input  1  clears short_blank_err.
REQ-011 out_ch0, out_ch1, out_ch2  output  10 each  registered words to the per-channel 10:1 serializers, one word per pixel_clk.
REQ-012 short_blank_err  output  1  sticky flag: blanking too short for insertion.

Function
REQ-013 SHALL delay de, hsync, vsync and the three video words by exactly L cycles, then register once: input-to-output latency L+1 cycles (11 at defaults).
REQ-014 Control tokens by {c1,c0}: 00 -> 1101010100, 01 -> 0010101011, 10 -> 0101010100, 11 -> 1010101011 (bit9..bit0).
REQ-015 Delayed de=1: out_chN = delayed vid_chN.
REQ-016 Delayed de=0, no insertion: ch0 = token{vsync,hsync}; ch1 = token 00; ch2 = token 00.
REQ-017 SHALL keep a saturating 4-bit count of consecutive de_in=0 cycles, cleared on any de_in=1, saturating at 15.
REQ-018 DE rising edge at input cycle t (de_in=1, previous de_in=0) SHALL be "qualified" iff hdmi_mode=1 at t and blank count >= MIN_BLANK at t-1.
REQ-019 Qualified edge: output words of input cycles t-L..t-L+PREAMBLE_LEN-1 SHALL be preamble (ch0 = token{vsync,hsync} of that cycle; ch1 = 0010101011; ch2 = 1101010100).
REQ-020 Qualified edge: output words of input cycles t-GUARD_LEN..t-1 SHALL be guard band (ch0 = 1011001100; ch1 = 0100110011; ch2 = 1011001100); word of cycle t is video.
REQ-021 SHALL sequence insertion with an FSM CTRL -> PRE (PREAMBLE_LEN words) -> GUARD (GUARD_LEN words) -> VIDEO -> CTRL when delayed de falls; CTRL -> PRE only on a qualified edge.
REQ-022 hdmi_mode SHALL be sampled only at DE rising edges; changes mid-line or mid-insertion SHALL NOT alter an insertion in progress.
REQ-023 Unqualified edge with hdmi_mode=1: no insertion (REQ-016 output), short_blank_err set on the following edge.
REQ-024 hdmi_mode=0: no insertion, short_blank_err never set.
REQ-025 short_blank_err SHALL hold until err_clr=1 or rst; a simultaneous set and err_clr SHALL leave it set.
REQ-026 Edges before MIN_BLANK blank cycles after reset release are unqualified (count restarts at 0).

Reset
REQ-027 rst=1 at an edge SHALL clear delay pipeline (de/hsync/vsync/video = 0), FSM to CTRL, blank count to 0, short_blank_err to 0.
REQ-028 Output on the edge after rst, and until pipeline refill: out_ch0..2 = 1101010100.
REQ-029 rst asserted mid-insertion or mid-video SHALL abort immediately; no remaining preamble/guard words emitted.

Verification
REQ-030 Reset, then 20 blank cycles (hs=vs=0), de_in rises at cycle 20 with hdmi_mode=1 -> outputs for input cycles 10..17 ch1=0010101011, 18..19 guard words, cycle 20 video word appears on out at cycle 31; err=0.
REQ-031 Same, hdmi_mode=0 -> no preamble/guard; all blank words 1101010100; video at cycle 31.
REQ-032 Blank gap of 11 cycles between lines, hdmi_mode=1 -> no insertion for second line, short_blank_err=1 and sticky; err_clr pulse -> 0.
REQ-033 vsync_in=1, hsync_in=0 during preamble -> ch0 = 0101010100 on preamble words, ch0 = 1011001100 on guard words.
REQ-034 rst pulsed during GUARD -> next out all 1101010100; following qualified edge after 12 blank cycles inserts normally.
REQ-035 hdmi_mode toggled 1->0 during PRE -> full preamble+guard still emitted; next line follows mode 0.
